// File: rtl/ext_cal_sequencer.sv
// ext_cal_sequencer: external-calibration sequencer driving the RF-switch GPIO
// control word through IDLE -> ADV -> TX -> GAP phases for one channel, with
// a programmable number of TX bursts per run.
// Build option: define EXT_CAL_CONT_EN to enable continuous mode (burst_num == 0
// repeats bursts until abort). Without it, burst_num == 0 runs a single burst.
module ext_cal_sequencer #(
    parameter int NUM_CH = 4,
    parameter int GPIO_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [3:0]               cal_sel,
    input  logic [CNT_W-1:0]         adv_len,
    input  logic [CNT_W-1:0]         tx_len,
    input  logic [CNT_W-1:0]         gap_len,
    input  logic [7:0]               burst_num,
    input  logic [GPIO_W-1:0]        rx_word,
    input  logic [GPIO_W-1:0]        adv_word,
    input  logic [NUM_CH*GPIO_W-1:0] tx_words,
    output logic [GPIO_W-1:0]        gpio_out,
    output logic                     busy,
    output logic                     tx_active,
    output logic                     done,
    output logic                     start_err,
    output logic [7:0]               burst_idx
);

    typedef enum logic [1:0] {S_IDLE, S_ADV, S_TX, S_GAP} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   adv_len_q;
    logic [CNT_W-1:0]   tx_len_q;
    logic [CNT_W-1:0]   gap_len_q;
    logic [7:0]         burst_num_q;
    logic [GPIO_W-1:0]  adv_word_q;
    logic [GPIO_W-1:0]  rx_word_q;
    logic [GPIO_W-1:0]  tx_word_q;
    logic [GPIO_W-1:0]  sel_word;
    logic               sel_ok;
    logic               last_burst;

    // Pick the TX word of the requested channel (channels are numbered from 1)
    always_comb begin
        sel_word = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            if (cal_sel == 4'(k)) begin
                sel_word = tx_words[k*GPIO_W-1 -: GPIO_W];
            end
        end
    end

    assign sel_ok = (cal_sel != 4'd0) && (int'(cal_sel) <= NUM_CH);

`ifdef EXT_CAL_CONT_EN
    // A latched burst count of zero never matches, so the run only ends on abort
    assign last_burst = (burst_num_q != 8'd0) && ((burst_idx + 8'd1) == burst_num_q);
`else
    // burst_num_q is latched as at least 1, so zero behaves as a single burst
    assign last_burst = ((burst_idx + 8'd1) == burst_num_q);
`endif

    // Phase sequencing, latching of run parameters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            adv_len_q   <= '0;
            tx_len_q    <= '0;
            gap_len_q   <= '0;
            burst_num_q <= '0;
            adv_word_q  <= '0;
            rx_word_q   <= '0;
            tx_word_q   <= '0;
            gpio_out    <= '0;
            busy        <= 1'b0;
            tx_active   <= 1'b0;
            done        <= 1'b0;
            start_err   <= 1'b0;
            burst_idx   <= '0;
        end else begin
            done      <= 1'b0;
            start_err <= 1'b0;
            if (state != S_IDLE && abort) begin
                state     <= S_IDLE;
                cnt       <= '0;
                gpio_out  <= rx_word;
                busy      <= 1'b0;
                tx_active <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        gpio_out <= rx_word;
                        if (start && !abort) begin
                            if (sel_ok && tx_len != '0) begin
                                adv_len_q  <= adv_len;
                                tx_len_q   <= tx_len;
                                gap_len_q  <= gap_len;
`ifdef EXT_CAL_CONT_EN
                                burst_num_q <= burst_num;
`else
                                burst_num_q <= (burst_num == 8'd0) ? 8'd1 : burst_num;
`endif
                                adv_word_q <= adv_word;
                                rx_word_q  <= rx_word;
                                tx_word_q  <= sel_word;
                                burst_idx  <= '0;
                                cnt        <= '0;
                                busy       <= 1'b1;
                                tx_active  <= 1'b1;
                                if (adv_len == '0) begin
                                    state    <= S_TX;
                                    gpio_out <= sel_word;
                                end else begin
                                    state    <= S_ADV;
                                    gpio_out <= adv_word;
                                end
                            end else begin
                                start_err <= 1'b1;
                            end
                        end
                    end
                    S_ADV: begin
                        if (cnt == adv_len_q - CNT_ONE) begin
                            cnt      <= '0;
                            state    <= S_TX;
                            gpio_out <= tx_word_q;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_TX: begin
                        if (cnt == tx_len_q - CNT_ONE) begin
                            cnt       <= '0;
                            burst_idx <= burst_idx + 8'd1;
                            if (last_burst) begin
                                state     <= S_IDLE;
                                done      <= 1'b1;
                                gpio_out  <= rx_word;
                                busy      <= 1'b0;
                                tx_active <= 1'b0;
                            end else if (gap_len_q != '0) begin
                                state     <= S_GAP;
                                gpio_out  <= rx_word_q;
                                tx_active <= 1'b0;
                            end else if (adv_len_q != '0) begin
                                state    <= S_ADV;
                                gpio_out <= adv_word_q;
                            end else begin
                                gpio_out <= tx_word_q;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_GAP: begin
                        if (cnt == gap_len_q - CNT_ONE) begin
                            cnt       <= '0;
                            tx_active <= 1'b1;
                            if (adv_len_q != '0) begin
                                state    <= S_ADV;
                                gpio_out <= adv_word_q;
                            end else begin
                                state    <= S_TX;
                                gpio_out <= tx_word_q;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ext_cal_sequencer.sv
// Directed self-checking bench for ext_cal_sequencer (default parameters).
module tb_ext_cal_sequencer;

    localparam int NUM_CH = 4;
    localparam int GPIO_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [31:0] RX0  = 32'hAAAA_0000;
    localparam logic [31:0] RX1  = 32'h5555_0000;
    localparam logic [31:0] ADVW = 32'hADD0_ADD0;
    localparam logic [31:0] CH1  = 32'h1111_0001;
    localparam logic [31:0] CH2  = 32'h2222_0002;
    localparam logic [31:0] CH3  = 32'h3333_0003;
    localparam logic [31:0] CH4  = 32'h4444_0004;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic                     abort;
    logic [3:0]               cal_sel;
    logic [CNT_W-1:0]         adv_len;
    logic [CNT_W-1:0]         tx_len;
    logic [CNT_W-1:0]         gap_len;
    logic [7:0]               burst_num;
    logic [GPIO_W-1:0]        rx_word;
    logic [GPIO_W-1:0]        adv_word;
    logic [NUM_CH*GPIO_W-1:0] tx_words;
    logic [GPIO_W-1:0]        gpio_out;
    logic                     busy;
    logic                     tx_active;
    logic                     done;
    logic                     start_err;
    logic [7:0]               burst_idx;

    int compared   = 0;
    int mismatched = 0;
    int done_seen  = 0;
    int done_base;

    ext_cal_sequencer #(.NUM_CH(NUM_CH), .GPIO_W(GPIO_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cal_sel   (cal_sel),
        .adv_len   (adv_len),
        .tx_len    (tx_len),
        .gap_len   (gap_len),
        .burst_num (burst_num),
        .rx_word   (rx_word),
        .adv_word  (adv_word),
        .tx_words  (tx_words),
        .gpio_out  (gpio_out),
        .busy      (busy),
        .tx_active (tx_active),
        .done      (done),
        .start_err (start_err),
        .burst_idx (burst_idx)
    );

    always #5 clk = ~clk;

    // Count done pulses so runs that must never complete can be checked
    always @(posedge clk) if (done === 1'b1) done_seen++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cal_sel   = 4'd1;
        adv_len   = '0;
        tx_len    = 16'd1;
        gap_len   = '0;
        burst_num = 8'd1;
        rx_word   = RX0;
        adv_word  = ADVW;
        tx_words  = {CH4, CH3, CH2, CH1};

        // Reset values
        tick(3);
        check("rst_gpio", gpio_out, 0);
        check("rst_busy", busy, 0);
        check("rst_txact", tx_active, 0);
        check("rst_done", done, 0);
        check("rst_serr", start_err, 0);
        check("rst_bidx", burst_idx, 0);
        rst_n = 1'b1;
        tick(1);
        check("idle_rx", gpio_out, RX0);

        // Single burst: ADV 400, TX 1000 on channel 2
        cal_sel = 4'd2; adv_len = 16'd400; tx_len = 16'd1000; gap_len = '0; burst_num = 8'd1;
        do_start();
        check("t1_adv_first", gpio_out, ADVW);
        check("t1_busy", busy, 1);
        check("t1_txact", tx_active, 1);
        tick(399);
        check("t1_adv_last", gpio_out, ADVW);
        tick(1);
        check("t1_tx_first", gpio_out, CH2);
        tick(999);
        check("t1_tx_last", gpio_out, CH2);
        check("t1_no_done_yet", done, 0);
        tick(1);
        check("t1_done", done, 1);
        check("t1_idle_gpio", gpio_out, RX0);
        check("t1_busy_low", busy, 0);
        check("t1_txact_low", tx_active, 0);
        check("t1_bidx", burst_idx, 1);
        tick(1);
        check("t1_done_pulse", done, 0);

        // Rejected starts
        cal_sel = 4'd0; tx_len = 16'd8;
        do_start();
        check("err_sel0", start_err, 1);
        check("err_sel0_busy", busy, 0);
        check("err_sel0_gpio", gpio_out, RX0);
        tick(1);
        check("err_pulse", start_err, 0);
        cal_sel = 4'd5;
        do_start();
        check("err_sel5", start_err, 1);
        check("err_sel5_busy", busy, 0);
        cal_sel = 4'd1; tx_len = '0;
        do_start();
        check("err_txlen0", start_err, 1);
        check("err_txlen0_gpio", gpio_out, RX0);

        // abort together with start in IDLE: start ignored, no error
        tx_len = 16'd8; abort = 1'b1;
        do_start();
        abort = 1'b0;
        check("abst_busy", busy, 0);
        check("abst_serr", start_err, 0);

        // Three bursts without ADV, GAP 4; inputs disturbed mid-run
        cal_sel = 4'd3; adv_len = '0; tx_len = 16'd8; gap_len = 16'd4; burst_num = 8'd3;
        do_start();
        check("t3_tx_first", gpio_out, CH3);
        check("t3_txact", tx_active, 1);
        check("t3_bidx_clr", burst_idx, 0);
        tick(2);
        tx_words = {CH4, 32'hDEAD_0003, CH2, CH1};
        tx_len = 16'd2; rx_word = RX1; start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t3_busy_start_noerr", start_err, 0);
        check("t3_word_held", gpio_out, CH3);
        tick(4);
        check("t3_len_held", gpio_out, CH3);
        tick(1);
        check("t3_gap_rx_latched", gpio_out, RX0);
        check("t3_gap_txact", tx_active, 0);
        check("t3_gap_busy", busy, 1);
        check("t3_bidx1", burst_idx, 1);
        tick(3);
        check("t3_gap_last", gpio_out, RX0);
        tick(1);
        check("t3_tx2", gpio_out, CH3);
        check("t3_tx2_act", tx_active, 1);
        tick(19);
        check("t3_no_done_yet", done, 0);
        tick(1);
        check("t3_done", done, 1);
        check("t3_bidx3", burst_idx, 3);
        check("t3_idle_live_rx", gpio_out, RX1);
        tx_words = {CH4, CH3, CH2, CH1};
        rx_word = RX0;

        // burst_num = 0: continuous with the option, one burst without it
        cal_sel = 4'd4; adv_len = 16'd2; tx_len = 16'd1; gap_len = '0; burst_num = 8'd0;
        done_base = done_seen;
        do_start();
        check("c_adv", gpio_out, ADVW);
`ifdef EXT_CAL_CONT_EN
        tick(900);
        check("c_bidx_wrap", burst_idx, 44);
        check("c_still_busy", busy, 1);
        check("c_gpio_adv", gpio_out, ADVW);
        check("c_no_done", done_seen - done_base, 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("c_abort_busy", busy, 0);
        check("c_abort_done", done, 0);
        check("c_abort_bidx", burst_idx, 44);
        check("c_abort_gpio", gpio_out, RX0);
`else
        tick(2);
        check("c_tx", gpio_out, CH4);
        tick(1);
        check("c_done", done, 1);
        check("c_bidx1", burst_idx, 1);
        check("c_busy", busy, 0);
`endif

        // abort coinciding with the final TX cycle
        cal_sel = 4'd1; adv_len = '0; tx_len = 16'd4; burst_num = 8'd1;
        do_start();
        check("ab_tx", gpio_out, CH1);
        tick(3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_no_done", done, 0);
        check("ab_bidx", burst_idx, 0);
        check("ab_gpio", gpio_out, RX0);
        check("ab_txact", tx_active, 0);

        // Reset in the middle of ADV, then a clean run
        cal_sel = 4'd1; adv_len = 16'd10; tx_len = 16'd3; burst_num = 8'd1;
        do_start();
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("mr_gpio", gpio_out, 0);
        check("mr_busy", busy, 0);
        check("mr_txact", tx_active, 0);
        check("mr_bidx", burst_idx, 0);
        rst_n = 1'b1;
        tick(1);
        check("mr_idle_rx", gpio_out, RX0);
        do_start();
        check("mr_adv", gpio_out, ADVW);
        tick(10);
        check("mr_tx", gpio_out, CH1);
        tick(3);
        check("mr_done", done, 1);
        check("mr_bidx", burst_idx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ext_cal_sequencer.md
# ext_cal_sequencer

Parametrised external-calibration sequencer for the 5G front-end control path. On a start pulse it drives a GPIO control word through RX-idle, TX-advance, TX and gap phases for one selected calibration channel, repeating the TX burst a programmed number of times. It sits between the register bank and the RF-switch GPIO pins and generalises the fixed four-channel, single-burst calibration controller.

## Interface
- NUM_CH, 4, number of calibration channels (1..15)
- GPIO_W, 32, GPIO control word width
- CNT_W, 16, phase-length counter width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle start request
- abort  in  1  terminate sequence, return to RX
- cal_sel  in  4  channel select; valid 1..NUM_CH
- adv_len  in  CNT_W  TX-advance phase length, cycles (0 = skip phase)
- tx_len  in  CNT_W  TX phase length, cycles (0 = start rejected)
- gap_len  in  CNT_W  gap between bursts, cycles (0 = skip phase)
- burst_num  in  8  bursts per run; 0 = continuous (see Configuration)
- rx_word  in  GPIO_W  word for IDLE and GAP
- adv_word  in  GPIO_W  word for ADV
- tx_words  in  NUM_CH*GPIO_W  per-channel TX words, channel k at slice [k*GPIO_W-1 -: GPIO_W]
- gpio_out  out  GPIO_W  registered control word
- busy  out  1  high when state != IDLE
- tx_active  out  1  high in ADV or TX
- done  out  1  one-cycle pulse on normal completion
- start_err  out  1  one-cycle pulse on rejected start
- burst_idx  out  8  completed bursts in current run

## Operation
- States: IDLE, ADV, TX, GAP; one phase counter, one burst counter.
- IDLE: start with 1 <= cal_sel <= NUM_CH and tx_len != 0 -> latch cal_sel, adv_len, tx_len, gap_len, burst_num, adv_word, rx_word, selected tx word; go ADV (TX if adv_len == 0). Otherwise start -> start_err, stay IDLE.
- ADV: counter 0..adv_len-1; at adv_len-1 -> TX, counter cleared.
- TX: counter 0..tx_len-1; at tx_len-1 burst_idx += 1; if burst_num != 0 and burst_idx+1 == burst_num -> IDLE with done; else -> GAP (ADV if gap_len == 0, TX if both 0).
- GAP: at gap_len-1 -> ADV (TX if latched adv_len == 0).
- gpio_out: IDLE = live rx_word; ADV = latched adv_word; TX = latched tx word; GAP = latched rx_word.
- Input changes during a run have no effect; only latched values are used.
- burst_idx cleared on accepted start; holds final value in IDLE; wraps 255 -> 0 in continuous mode.
- abort in any non-IDLE state -> IDLE next edge, no done, counters cleared, burst_idx holds.

## Timing
- Reset: state IDLE, gpio_out = 0, busy 0, tx_active 0, done 0, start_err 0, burst_idx 0, counters 0. Reset mid-run has the same effect.
- All outputs registered; gpio_out, busy and tx_active change on the same edge as state.
- start sampled at edge N -> first phase word on gpio_out from N+1.
- Each phase lasts exactly its programmed length in cycles.
- done and the IDLE transition occur on the same edge; done high one cycle.
- start while busy: ignored, no start_err.
- abort and start in the same cycle in IDLE: start ignored, no start_err.
- abort with the last TX cycle: abort wins, no done.

## Configuration
- EXT_CAL_CONT_EN defined: burst_num == 0 runs bursts indefinitely until abort; done never pulses.
- EXT_CAL_CONT_EN undefined: burst_num == 0 is treated as 1; continuous-mode logic absent.

## Test plan
- NUM_CH=4, cal_sel=2, adv_len=400, tx_len=1000, gap_len=0, burst_num=1 -> adv_word for 400 cycles, tx_words[2] for 1000 cycles, done at cycle 1401, then rx_word.
- cal_sel=0 or 5, then tx_len=0, each with start -> start_err pulse each time, gpio_out stays rx_word, busy 0.
- adv_len=0, tx_len=8, gap_len=4, burst_num=3 -> TX8, GAP4, TX8, GAP4, TX8, done; burst_idx ends at 3.
- burst_num=0 with EXT_CAL_CONT_EN defined -> bursts continue past 300, burst_idx wraps; abort -> IDLE next edge, no done. Without the macro -> single burst then done.
- Change tx_words and tx_len mid-TX -> gpio_out and phase length unchanged until the next run.
- rst_n low mid-ADV -> all outputs at reset values next edge; start after release runs normally.
